serial_add_ctrl: RTL

Bit-serial adder/subtractor controller that time-multiplexes a single 1-bit full adder (`fa`) to add or subtract two WIDTH-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and the sequencing FSM. It exposes valid/ready handshakes on both input and result sides, so it sits between an operand producer and a result consumer wherever area matters more than throughput.

---
 rtl/serial_add_pkg.sv | 9 +
 rtl/fa.sv | 11 +
 rtl/serial_add_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM encoding and counter sizing for the bit-serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/fa.sv
// fa: 1-bit full adder
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial add/sub sequencing one shared full adder
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_hold;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_cout, last;
  fa u_fa (.a(a_sh[0]), .b(b_sh[0]), .c(carry), .sum(fa_sum), .cout(fa_cout));
  assign last      = cnt == CW'(WIDTH - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // sum_sh is cleared on accept, so a copy keeps the previous result visible in IDLE/RUN
  assign out_sum   = out_valid ? sum_sh : sum_hold;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
               (state == RUN)  ? (last ? DONE : RUN) :
               (state == DONE) ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      sum_hold <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh   <= in_a;
      b_sh   <= in_sub ? ~in_b : in_b;
      carry  <= in_sub;
      sum_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= last ? cnt : cnt + CW'(1);
      if (last) begin
        out_cout <= fa_cout;
        out_ovf  <= carry ^ fa_cout;
      end
    end else if (state == DONE) begin
      sum_hold <= sum_sh;
    end
  end
endmodule
